lcd_sequencer: RTL and testbench

//  Front-end controller for the 4-bit character LCD. After reset it runs the LCD

---
 rtl/lcd_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sequencer.sv
// 4-bit character LCD front end: power-up nibble sequence, configuration bytes,
// then valid/ready byte writes through an external timing_fsm. Optional macro LCD_CURSOR_EN.
module lcd_sequencer #(
   parameter int PWRUP_CYC = 750000,
   parameter int GAP1_CYC  = 205000,
   parameter int GAP2_CYC  = 5000,
   parameter int GAP3_CYC  = 2000,
   parameter int NIB_E_CYC = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       init_done,
   output logic       tfsm_en,
   input  logic [2:0] tfsm_state,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [3:0] lcd_db
);

`ifdef LCD_CURSOR_EN
   localparam logic [7:0] DISP_CMD = 8'h0F;
`else
   localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

   localparam logic [19:0] PWR_LIM = 20'(PWRUP_CYC - 1);
   localparam logic [19:0] E_LIM   = 20'(NIB_E_CYC - 1);

   typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, CFG, IDLE, SEND} state_t;
   typedef enum logic [1:0] {NIB_SETUP, NIB_EHI, NIB_GAP} phase_t;

   state_t      state_reg, state_next;
   phase_t      phase_reg, phase_next;
   logic [19:0] cnt_reg, cnt_next;
   logic [1:0]  idx_reg, idx_next;
   logic [7:0]  byte_reg, byte_next;
   logic        rs_reg, rs_next;
   logic        seen_reg, seen_next;
   logic        done_reg, done_next;
   logic        busy;

   function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return DISP_CMD;
         default: return 8'h01;
      endcase
   endfunction

   function automatic logic [19:0] gap_lim(input logic [1:0] idx);
      case (idx)
         2'd0:    return 20'(GAP1_CYC - 1);
         2'd1:    return 20'(GAP2_CYC - 1);
         default: return 20'(GAP3_CYC - 1);
      endcase
   endfunction

   assign busy      = (tfsm_state != 3'd0);
   assign lcd_rw    = 1'b0;
   assign init_done = done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= PWR_WAIT;
         phase_reg <= NIB_SETUP;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         byte_reg  <= '0;
         rs_reg    <= 1'b0;
         seen_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         byte_reg  <= byte_next;
         rs_reg    <= rs_next;
         seen_reg  <= seen_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      byte_next  = byte_reg;
      rs_next    = rs_reg;
      seen_next  = seen_reg;
      done_next  = done_reg;
      req_ready  = 1'b0;
      tfsm_en    = 1'b0;
      lcd_e      = 1'b0;
      lcd_rs     = 1'b0;
      lcd_db     = 4'h0;
      case (state_reg)
         PWR_WAIT: begin
            if (cnt_reg == PWR_LIM) begin
               state_next = INIT_NIB;
               phase_next = NIB_SETUP;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + 20'd1;
            end
         end
         INIT_NIB: begin
            // Nibble stays on the bus from setup through the whole gap
            lcd_db = (idx_reg == 2'd3) ? 4'h2 : 4'h3;
            case (phase_reg)
               NIB_SETUP: begin
                  phase_next = NIB_EHI;
                  cnt_next   = '0;
               end
               NIB_EHI: begin
                  lcd_e = 1'b1;
                  if (cnt_reg == E_LIM) begin
                     phase_next = NIB_GAP;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_reg + 20'd1;
                  end
               end
               default: begin
                  if (cnt_reg == gap_lim(idx_reg)) begin
                     cnt_next = '0;
                     if (idx_reg == 2'd3) begin
                        state_next = CFG;
                        idx_next   = '0;
                        byte_next  = cfg_byte(2'd0);
                        rs_next    = 1'b0;
                        seen_next  = 1'b0;
                     end else begin
                        idx_next   = idx_reg + 2'd1;
                        phase_next = NIB_SETUP;
                     end
                  end else begin
                     cnt_next = cnt_reg + 20'd1;
                  end
               end
            endcase
         end
         CFG, SEND: begin
            lcd_rs  = rs_reg;
            lcd_e   = (tfsm_state == 3'd1) || (tfsm_state == 3'd3);
            tfsm_en = !seen_reg && !busy;
            case (tfsm_state)
               3'd1, 3'd2:       lcd_db = byte_reg[7:4];
               3'd3, 3'd4, 3'd5: lcd_db = byte_reg[3:0];
               default:          lcd_db = 4'h0;
            endcase
            // Any nonzero code, legal or not, counts as the write being in flight
            if (busy) begin
               seen_next = 1'b1;
            end else if (seen_reg) begin
               seen_next = 1'b0;
               if (state_reg == SEND) begin
                  state_next = IDLE;
               end else if (idx_reg == 2'd3) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next  = idx_reg + 2'd1;
                  byte_next = cfg_byte(idx_reg + 2'd1);
               end
            end
         end
         IDLE: begin
            req_ready = !busy;
            if (req_valid && !busy) begin
               byte_next  = req_data;
               rs_next    = req_rs;
               seen_next  = 1'b0;
               state_next = SEND;
            end
         end
         default: state_next = PWR_WAIT;
      endcase
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a small timing_fsm model on tfsm_en/tfsm_state.
module tb_lcd_sequencer;
   localparam int PW = 100;
   localparam int G1 = 50;
   localparam int G2 = 20;
   localparam int G3 = 10;
   localparam int NE = 4;
   localparam int D  = 3;

`ifdef LCD_CURSOR_EN
   localparam logic [3:0] DISP_LO = 4'hF;
`else
   localparam logic [3:0] DISP_LO = 4'hC;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, init_done, tfsm_en, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_db;
   logic [2:0] cs;
   int         mcnt;
   logic       bad_inject = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   logic [3:0] db_q[$];
   logic       rs_q[$];
   int         lo_q[$];
   int         hi_q[$];
   logic       prev_e;
   int         hi_cnt, lo_cnt;

   logic [3:0] exp_init [12];

   always #5 clk = ~clk;

   lcd_sequencer #(
      .PWRUP_CYC(PW), .GAP1_CYC(G1), .GAP2_CYC(G2), .GAP3_CYC(G3), .NIB_E_CYC(NE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
      .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
      .tfsm_en(tfsm_en), .tfsm_state(cs), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_db(lcd_db)
   );

   // timing_fsm model: idle -> E-hi upper -> E-lo -> E-hi lower -> wait -> wait (-> 6) -> idle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs   <= 3'd0;
         mcnt <= 0;
      end else if (cs == 3'd0) begin
         if (tfsm_en) begin
            cs   <= 3'd1;
            mcnt <= 0;
         end
      end else if (mcnt == D - 1) begin
         mcnt <= 0;
         case (cs)
            3'd5:    cs <= bad_inject ? 3'd6 : 3'd0;
            3'd6:    cs <= 3'd0;
            default: cs <= cs + 3'd1;
         endcase
      end else begin
         mcnt <= mcnt + 1;
      end
   end

   // Record every lcd_e pulse: nibble and rs at rise, low run before it, high width
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_e = 1'b0;
         hi_cnt = 0;
         lo_cnt = 0;
      end else begin
         if (lcd_e) begin
            if (!prev_e) begin
               db_q.push_back(lcd_db);
               rs_q.push_back(lcd_rs);
               lo_q.push_back(lo_cnt);
               lo_cnt = 0;
               hi_cnt = 1;
            end else begin
               hi_cnt++;
            end
         end else begin
            if (prev_e) hi_q.push_back(hi_cnt);
            lo_cnt++;
         end
         prev_e = lcd_e;
      end
   end

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (lcd_e !== 1'b0 || lcd_db !== 4'h0 || lcd_rs !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_lcd: e=%b db=%h rs=%b, required 0 0 0", lcd_e, lcd_db, lcd_rs);
      end
      tests_run++;
      if (req_ready !== 1'b0 || tfsm_en !== 1'b0 || init_done !== 1'b0 || lcd_rw !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctl: ready=%b en=%b done=%b rw=%b, required 0 0 0 0",
                  req_ready, tfsm_en, init_done, lcd_rw);
      end
      $display("[TB] reset held, outputs sampled");
   endtask

   task automatic test_pwrup;
      int cyc;
      logic [3:0] db100;
      logic e100;
      cyc = 0;
      db100 = 4'hF;
      e100 = 1'b1;
      db_q.delete(); rs_q.delete(); lo_q.delete(); hi_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      while (cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 100) begin
            db100 = lcd_db;
            e100 = lcd_e;
         end
         if (lcd_e) break;
      end
      tests_run++;
      if (cyc !== 101) begin
         tests_failed++;
         $display("FAIL pwrup_e_rise: first lcd_e at cycle %0d, required 101", cyc);
      end
      tests_run++;
      if (db100 !== 4'h3 || e100 !== 1'b0) begin
         tests_failed++;
         $display("FAIL pwrup_setup: cycle 100 db=%h e=%b, required db=3 e=0", db100, e100);
      end
      tests_run++;
      if (lcd_db !== 4'h3 || lcd_rs !== 1'b0) begin
         tests_failed++;
         $display("FAIL pwrup_first_nib: db=%h rs=%b, required 3 0", lcd_db, lcd_rs);
      end
      $display("[TB] power-up: first lcd_e at cycle %0d db=%h", cyc, lcd_db);
   endtask

   task automatic test_init;
      int cyc;
      int nq;
      logic rs_bad;
      cyc = 0;
      while (!init_done && cyc < 5000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      nq = db_q.size();
      tests_run++;
      if (init_done !== 1'b1 || nq !== 12) begin
         tests_failed++;
         $display("FAIL init_done: done=%b after %0d pulses, required 1 after 12", init_done, nq);
      end
      for (int i = 0; i < 12; i++) begin
         tests_run++;
         if (i >= nq || db_q[i] !== exp_init[i]) begin
            tests_failed++;
            $display("FAIL init_nib%0d: db=%h, required %h", i, (i < nq) ? db_q[i] : 4'hx, exp_init[i]);
         end
      end
      rs_bad = 1'b0;
      for (int i = 0; i < nq; i++) if (rs_q[i] !== 1'b0) rs_bad = 1'b1;
      tests_run++;
      if (rs_bad !== 1'b0) begin
         tests_failed++;
         $display("FAIL init_rs: rs high on an init pulse, required 0");
      end
      tests_run++;
      if (hi_q.size() < 5 || hi_q[0] != NE || hi_q[1] != NE || hi_q[2] != NE || hi_q[3] != NE
          || hi_q[4] != D) begin
         tests_failed++;
         $display("FAIL init_e_width: widths %p, required %0d x4 then %0d", hi_q, NE, D);
      end
      tests_run++;
      if (nq < 4 || lo_q[1] != G1 + 1 || lo_q[2] != G2 + 1 || lo_q[3] != G3 + 1) begin
         tests_failed++;
         $display("FAIL init_gaps: low runs %p, required %0d %0d %0d at 1..3", lo_q, G1 + 1, G2 + 1, G3 + 1);
      end
      $display("[TB] init: %0d pulses, init_done=%b", nq, init_done);
   endtask

   task automatic test_char;
      int base;
      int cyc;
      base = db_q.size();
      @(negedge clk);
      req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
      #1;
      tests_run++;
      if (req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL char_ready: ready=%b, required 1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      tests_run++;
      if (req_ready !== 1'b0 || tfsm_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL char_start: ready=%b en=%b, required 0 1", req_ready, tfsm_en);
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(req_ready && db_q.size() >= base + 2) && cyc < 400);
      tests_run++;
      if (db_q.size() < base + 2 || db_q[base] !== 4'h4 || db_q[base+1] !== 4'h1
          || rs_q[base] !== 1'b1 || rs_q[base+1] !== 1'b1 || lcd_rw !== 1'b0) begin
         tests_failed++;
         $display("FAIL char_41: %0d pulses, db %p rs %p rw=%b, required 4,1 rs 1,1 rw 0",
                  db_q.size() - base, db_q, rs_q, lcd_rw);
      end
      $display("[TB] char 0x41 rs=1 sent in %0d cycles", cyc);
   endtask

   task automatic test_back_to_back;
      int base, acc, n_at2, cyc;
      logic ready_err;
      base = db_q.size();
      acc = 0;
      n_at2 = -1;
      ready_err = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h55;
      for (cyc = 0; cyc < 400 && acc < 2; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (req_ready && cs != 3'd0) ready_err = 1'b1;
         if (req_ready) begin
            if (acc == 1) n_at2 = db_q.size() - base;
            @(posedge clk);
            #1;
            acc++;
            $display("[TB] back-to-back: byte %0d accepted", acc);
            if (acc == 1) begin
               req_rs = 1'b1; req_data = 8'hA3;
            end
         end
      end
      req_valid = 1'b0;
      tests_run++;
      if (acc !== 2 || n_at2 !== 2) begin
         tests_failed++;
         $display("FAIL b2b_accept: accepts=%0d pulses before 2nd=%0d, required 2 and 2", acc, n_at2);
      end
      tests_run++;
      if (ready_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_ready_busy: ready seen with tfsm_state!=0, required never");
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(req_ready && db_q.size() >= base + 4) && cyc < 400);
      tests_run++;
      if (db_q.size() < base + 4 || db_q[base] !== 4'h5 || db_q[base+1] !== 4'h5
          || db_q[base+2] !== 4'hA || db_q[base+3] !== 4'h3) begin
         tests_failed++;
         $display("FAIL b2b_data: db %p, required 5,5,A,3 from index %0d", db_q, base);
      end
      tests_run++;
      if (db_q.size() < base + 4 || rs_q[base] !== 1'b0 || rs_q[base+1] !== 1'b0
          || rs_q[base+2] !== 1'b1 || rs_q[base+3] !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_rs: rs %p, required 0,0,1,1 from index %0d", rs_q, base);
      end
   endtask

   task automatic test_illegal;
      int base, cyc;
      logic saw6, err6;
      base = db_q.size();
      saw6 = 1'b0;
      err6 = 1'b0;
      bad_inject = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h7E;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cs == 3'd6) begin
            saw6 = 1'b1;
            if (tfsm_en || req_ready) err6 = 1'b1;
         end
      end while (!req_ready && cyc < 400);
      bad_inject = 1'b0;
      tests_run++;
      if (err6 !== 1'b0 || saw6 !== 1'b1 || req_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL illegal_state: err=%b saw6=%b ready=%b, required 0 1 1", err6, saw6, req_ready);
      end
      tests_run++;
      if (db_q.size() < base + 2 || db_q[base] !== 4'h7 || db_q[base+1] !== 4'hE) begin
         tests_failed++;
         $display("FAIL illegal_data: db %p, required 7,E from index %0d", db_q, base);
      end
      $display("[TB] byte 0x7E through illegal state 6, done after %0d cycles", cyc);
   endtask

   task automatic test_reset_mid;
      int cyc;
      @(negedge clk);
      req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h9C;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (cs != 3'd1 && cyc < 50);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (lcd_e !== 1'b0 || lcd_db !== 4'h0 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_lcd: e=%b db=%h rs=%b rw=%b, required 0", lcd_e, lcd_db, lcd_rs, lcd_rw);
      end
      tests_run++;
      if (req_ready !== 1'b0 || tfsm_en !== 1'b0 || init_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_ctl: ready=%b en=%b done=%b, required 0", req_ready, tfsm_en, init_done);
      end
      $display("[TB] reset during upper nibble of 0x9C");
      repeat (2) @(posedge clk);
      test_pwrup();
   endtask

   initial begin
      exp_init = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, DISP_LO, 4'h0, 4'h1};
      test_reset();
      test_pwrup();
      test_init();
      test_char();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
